// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder and its benches.
// Holds the responder FSM encoding, address/data widths and signature defaults.
// No logic; pure types and constants.
package mips_mem_pkg;

    localparam int WORD_W      = 32;
    localparam int BYTE_ADDR_W = 32;
    localparam int WORD_IDX_W  = BYTE_ADDR_W - 2;

    // Default store-signature constants (byte addresses / data value)
    localparam logic [BYTE_ADDR_W-1:0] DEF_SIG_ADDR     = 32'd84;
    localparam logic [WORD_W-1:0]      DEF_SIG_DATA     = 32'd7;
    localparam logic [BYTE_ADDR_W-1:0] DEF_SCRATCH_ADDR = 32'd80;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM backing the data-memory responder.
// Read data registered one cycle after the address; write on the same edge.
// No flow control and no reset: contents survive responder reset.
module dmem_ram
    import mips_mem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter     INIT_FILE = "",
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Synchronous write and registered read (read returns pre-write data)
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with wait states and an embedded store-signature checker.
// Latency: ready pulses LATENCY cycles after the accepting edge; one request per LATENCY+1 cycles.
// Backpressure: req is held until ready; req is ignored while a request is in flight.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int                      DEPTH        = 64,
    parameter int                      LATENCY      = 2,
    parameter logic [BYTE_ADDR_W-1:0]  SIG_ADDR     = DEF_SIG_ADDR,
    parameter logic [WORD_W-1:0]       SIG_DATA     = DEF_SIG_DATA,
    parameter logic [BYTE_ADDR_W-1:0]  SCRATCH_ADDR = DEF_SCRATCH_ADDR,
    parameter                          INIT_FILE    = ""
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [BYTE_ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0]      wdata,
    output logic [WORD_W-1:0]      rdata,
    output logic                   ready,
    output logic                   err,
    output logic                   pass,
    output logic                   fail,
    output logic [15:0]            write_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t        state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx_q;
    logic              we_q;
    logic              bad_q;

    logic              bad_now;
    logic              accept;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [WORD_W-1:0] ram_q;

    // Misaligned or beyond-the-array accesses are answered with err and touch nothing
    always_comb begin
        bad_now  = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
        accept   = (state == S_IDLE) && req;
        ram_we   = accept && we && !bad_now;
        // Present the live address while idle so the read starts at acceptance
        ram_addr = (state == S_IDLE) ? addr[AW+1:2] : idx_q;
    end

    dmem_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_q)
    );

    // Request FSM with registered ready/err/rdata, store counter and sticky signature flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            ready       <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            write_count <= 16'd0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q <= addr[AW+1:2];
                        we_q  <= we;
                        bad_q <= bad_now;
                        cnt   <= 4'(LATENCY - 1);
                        state <= (LATENCY == 1) ? S_RESP : S_WAIT;
                        if (we && !bad_now) begin
                            if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
                            // First flag to set wins; the other stays low until reset
                            if (addr == SIG_ADDR && wdata == SIG_DATA) begin
                                if (!fail) pass <= 1'b1;
                            end else if (addr != SCRATCH_ADDR) begin
                                if (!pass) fail <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    err   <= bad_q;
                    // Store responses leave the last load data in place
                    if (bad_q)      rdata <= '0;
                    else if (!we_q) rdata <= ram_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level model plus directed vectors.
// Model tracks acceptance slots, RAM image, sticky flags and store count per cycle.
// Directed sequences pin latency, throughput, error handling and reset behaviour.
module tb_dmem_responder;
    import mips_mem_pkg::*;

    localparam int LAT = 2;
    localparam int DEP = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        pass;
    logic        fail;
    logic [15:0] write_count;

    dmem_responder #(
        .DEPTH        (DEP),
        .LATENCY      (LAT),
        .SIG_ADDR     (DEF_SIG_ADDR),
        .SIG_DATA     (DEF_SIG_DATA),
        .SCRATCH_ADDR (DEF_SCRATCH_ADDR),
        .INIT_FILE    ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .err         (err),
        .pass        (pass),
        .fail        (fail),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_mem [DEP];
    int          cyc     = 0;
    int          next_ok = 0;
    int          resp_at = -1;
    logic        p_err   = 1'b0;
    logic        p_we    = 1'b0;
    logic [31:0] p_data  = 32'd0;
    logic        m_ready = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_pass  = 1'b0;
    logic        m_fail  = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    int          m_wc    = 0;
    logic        armed   = 1'b0;

    initial begin
        for (int i = 0; i < DEP; i++) m_mem[i] = 32'd0;
    end

    // A request is taken on the first edge with req once the previous one has had
    // LATENCY+1 cycles; its response is visible for the cycle after edge +LATENCY.
    initial forever begin
        logic bad;
        @(posedge clk);
        cyc++;
        m_ready = 1'b0;
        m_err   = 1'b0;
        if (reset) begin
            if (cyc == resp_at) begin
                m_ready = 1'b1;
                m_err   = p_err;
                if (p_err)     m_rdata = 32'd0;
                else if (!p_we) m_rdata = p_data;
            end
            if (req && cyc >= next_ok) begin
                bad     = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEP);
                p_err   = bad;
                p_we    = we;
                p_data  = bad ? 32'd0 : m_mem[addr[7:2]];
                if (we && !bad) begin
                    m_mem[addr[7:2]] = wdata;
                    if (m_wc < 65535) m_wc++;
                    if (addr == DEF_SIG_ADDR && wdata == DEF_SIG_DATA) begin
                        if (!m_fail) m_pass = 1'b1;
                    end else if (addr != DEF_SCRATCH_ADDR) begin
                        if (!m_pass) m_fail = 1'b1;
                    end
                end
                resp_at = cyc + LAT;
                next_ok = cyc + LAT + 1;
            end
        end
    end

    // Asynchronous reset drops any in-flight request and clears visible state
    initial forever begin
        @(negedge reset);
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_pass  = 1'b0;
        m_fail  = 1'b0;
        m_rdata = 32'd0;
        m_wc    = 0;
        resp_at = -1;
        next_ok = 0;
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("cyc_ready", 32'(ready), 32'(m_ready));
            chk("cyc_err",   32'(err),   32'(m_err));
            chk("cyc_rdata", rdata,      m_rdata);
            chk("cyc_pass",  32'(pass),  32'(m_pass));
            chk("cyc_fail",  32'(fail),  32'(m_fail));
            chk("cyc_wcnt",  32'(write_count), 32'(m_wc));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 40);
        chk("req_completes", 32'(ready), 32'd1);
        req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        int cnt;
        int last;
        int c;

        repeat (2) @(negedge clk);
        reset = 1'b1;
        armed = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_pass",  32'(pass),  32'd0);
        chk("rst_fail",  32'(fail),  32'd0);
        chk("rst_rdata", rdata,      32'd0);
        chk("rst_wcnt",  32'(write_count), 32'd0);

        // Scratch store then load-back; ready seen on the 3rd falling edge after drive
        do_req(1'b1, 32'd80, 32'd5, lat);
        chk("st80_latency", 32'(lat), 32'd3);
        chk("st80_err",  32'(err),  32'd0);
        chk("st80_pass", 32'(pass), 32'd0);
        chk("st80_fail", 32'(fail), 32'd0);
        chk("st80_wcnt", 32'(write_count), 32'd1);
        do_req(1'b0, 32'd80, 32'd0, lat);
        chk("ld80_rdata", rdata, 32'd5);
        chk("ld80_err",   32'(err), 32'd0);

        // Pass signature, then an ordinary store must not raise fail
        do_reset();
        do_req(1'b1, 32'd84, 32'd7, lat);
        chk("sig_pass", 32'(pass), 32'd1);
        chk("sig_fail", 32'(fail), 32'd0);
        do_req(1'b1, 32'd0, 32'd1, lat);
        chk("after_pass_pass", 32'(pass), 32'd1);
        chk("after_pass_fail", 32'(fail), 32'd0);
        chk("after_pass_wcnt", 32'(write_count), 32'd2);

        // Wrong signature data fails, and a later correct one cannot recover
        do_reset();
        do_req(1'b1, 32'd84, 32'd6, lat);
        chk("badsig_fail", 32'(fail), 32'd1);
        chk("badsig_pass", 32'(pass), 32'd0);
        do_req(1'b1, 32'd84, 32'd7, lat);
        chk("late_sig_fail", 32'(fail), 32'd1);
        chk("late_sig_pass", 32'(pass), 32'd0);

        // Error accesses: misaligned and out of range
        do_reset();
        do_req(1'b0, 32'd80, 32'd0, lat);
        chk("pre_err_rdata", rdata, 32'd5);
        do_req(1'b0, 32'h102, 32'd0, lat);
        chk("mis_err",   32'(err), 32'd1);
        chk("mis_rdata", rdata,    32'd0);
        do_req(1'b0, 32'd256, 32'd0, lat);
        chk("oor_err",   32'(err), 32'd1);
        chk("oor_rdata", rdata,    32'd0);
        do_req(1'b1, 32'd257, 32'd9, lat);
        chk("err_st_err",  32'(err),  32'd1);
        chk("err_st_wcnt", 32'(write_count), 32'd0);
        chk("err_st_fail", 32'(fail), 32'd0);

        // req held high across four scratch stores
        do_reset();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'd80; wdata = 32'h100;
        cnt = 0; last = 0; c = 0;
        while (c < 60 && cnt < 4) begin
            @(negedge clk);
            c++;
            if (ready) begin
                if (cnt > 0) chk("hold_spacing", 32'(c - last), 32'd3);
                last = c;
                cnt++;
                wdata = 32'h100 + 32'(cnt);
            end
        end
        req = 1'b0;
        chk("hold_pulses", 32'(cnt), 32'd4);
        chk("hold_wcnt",   32'(write_count), 32'd4);

        // Reset while a load is waiting
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(ready), 32'd0);
        end
        do_req(1'b0, 32'd80, 32'd0, lat);
        chk("ram_keep_80", rdata, 32'h103);
        do_req(1'b0, 32'd0, 32'd0, lat);
        chk("ram_keep_0", rdata, 32'd1);

        repeat (3) @(negedge clk);
        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench timeout");
    end

endmodule
